mac_inverse_div: RTL

Sequential inverse of the multiply-accumulate pipeline: it recovers the operand `A` from a pipeline result `DATA_IN = A*B + C` by computing `(DATA_IN - C) / B` with a one-bit-per-cycle restoring divider. It sits on the consumer side of the MAC datapath, for example in checkers and decoders that must undo the accumulate. Operands enter and results leave through valid/ready handshakes.

---
 rtl/mac_inverse_div_pkg.sv | 21 ++
 rtl/div_step.sv | 23 ++
 rtl/mac_inverse_div.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mac_inverse_div_pkg.sv
// Shared constants and types for the MAC inverse divider.
package mac_inverse_div_pkg;

  localparam int WIDTH     = 8;
  localparam int OUT_WIDTH = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic div_zero;
    logic underflow;
    logic overflow;
    logic exact;
  } flags_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = mac_inverse_div_pkg::WIDTH
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_rem,
  output logic             o_q
);

  localparam int RW = WIDTH + 1;

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_div_ext;

  // The shifted remainder gets one extra bit so the compare can never wrap.
  assign w_shift   = {i_rem, i_bit};
  assign w_div_ext = {2'b00, i_div};
  assign o_q       = (w_shift >= w_div_ext);
  assign o_rem     = o_q ? RW'(w_shift - w_div_ext) : RW'(w_shift);

endmodule

// File: rtl/mac_inverse_div.sv
// Recovers A from DATA_IN = A*B + C as (DATA_IN - C) / B, one quotient bit per cycle.
module mac_inverse_div #(
  parameter int WIDTH     = mac_inverse_div_pkg::WIDTH,
  parameter int OUT_WIDTH = mac_inverse_div_pkg::OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OUT_WIDTH-1:0] DATA_IN,
  input  logic [WIDTH-1:0]     B,
  input  logic [WIDTH-1:0]     C,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     A_out,
  output logic [WIDTH-1:0]     rem_out,
  output logic                 div_zero,
  output logic                 underflow,
  output logic                 overflow,
  output logic                 exact
);

  import mac_inverse_div_pkg::*;

  localparam int               CNT_W     = $clog2(OUT_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(OUT_WIDTH - 1);

  state_t               r_state;
  logic [OUT_WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_c;
  logic [WIDTH:0]       r_rem;
  logic [OUT_WIDTH-2:0] r_quot;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_a_out;
  logic [WIDTH-1:0]     r_rem_out;
  flags_t               r_flags;

  logic [OUT_WIDTH:0]   w_diff;
  logic [WIDTH:0]       w_step_rem;
  logic                 w_step_q;
  logic [OUT_WIDTH-1:0] w_quot;
  logic                 w_ovf;

  // Borrow out of the extra top bit means DATA_IN < C.
  assign w_diff = {1'b0, r_dividend} - {{(OUT_WIDTH + 1 - WIDTH){1'b0}}, r_c};

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem (r_rem),
    .i_bit (r_dividend[OUT_WIDTH-1]),
    .i_div (r_b),
    .o_rem (w_step_rem),
    .o_q   (w_step_q)
  );

  // Full quotient including the bit produced this cycle; its top half flags overflow.
  assign w_quot = {r_quot, w_step_q};
  assign w_ovf  = |w_quot[OUT_WIDTH-1:WIDTH];

  // Control FSM, divider datapath and registered result.
  // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too; the result must read 0 after reset.
      r_state     <= IDLE;
      r_dividend  <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_rem       <= '0;
      r_quot      <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_a_out     <= '0;
      r_rem_out   <= '0;
      r_flags     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dividend <= DATA_IN;
            r_b        <= B;
            r_c        <= C;
            r_state    <= SUB;
          end
        end
        SUB: begin
          if (r_b == '0) begin
            r_flags     <= '{div_zero: 1'b1, underflow: 1'b0, overflow: 1'b0, exact: 1'b0};
            r_a_out     <= '0;
            r_rem_out   <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else if (w_diff[OUT_WIDTH]) begin
            r_flags     <= '{div_zero: 1'b0, underflow: 1'b1, overflow: 1'b0, exact: 1'b0};
            r_a_out     <= '0;
            r_rem_out   <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_dividend <= w_diff[OUT_WIDTH-1:0];
            r_rem      <= '0;
            r_quot     <= '0;
            r_cnt      <= '0;
            r_state    <= DIV;
          end
        end
        DIV: begin
          r_dividend <= r_dividend << 1;
          r_rem      <= w_step_rem;
          r_quot     <= w_quot[OUT_WIDTH-2:0];
          r_cnt      <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_STEP) begin
            r_a_out     <= w_ovf ? '1 : w_quot[WIDTH-1:0];
            r_rem_out   <= w_step_rem[WIDTH-1:0];
            r_flags     <= '{div_zero: 1'b0, underflow: 1'b0, overflow: w_ovf,
                             exact: (!w_ovf && (w_step_rem == '0))};
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign A_out     = r_a_out;
  assign rem_out   = r_rem_out;
  assign div_zero  = r_flags.div_zero;
  assign underflow = r_flags.underflow;
  assign overflow  = r_flags.overflow;
  assign exact     = r_flags.exact;

endmodule
